// File: rtl/result_display.sv
// Result display: latches the ALU result, converts it to BCD in 16 cycles, then scans it onto an 8-digit 7-segment display.
// Latency is 17 edges from start to done; a start arriving mid-conversion is dropped, and there is no other backpressure.
module result_display #(
  parameter int SCAN_DIV   = 50000,
  parameter int NUM_DIGITS = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  IN_clk,
  input  logic                  IN_reset,
  input  logic                  IN_start,
  input  logic [7:0]            IN_RESH,
  input  logic [7:0]            IN_RESL,
  input  logic                  IN_err,
  output logic [7:0]            OUT_seg,
  output logic [NUM_DIGITS-1:0] OUT_sel,
  output logic                  OUT_busy,
  output logic                  OUT_done,
  output logic [1:0]            OUT_state
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_SHOW   = 2'd2,
    S_UNUSED = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   load_start, step_last;

  logic [15:0]   bin_q;
  logic [19:0]   bcd_q;
  logic [3:0]    iter_q;
  logic          err_q;
  logic [7:0]    dig_q [5];
  logic          disp_vld_q;
  logic          done_q;
  logic [CW-1:0] scan_cnt_q;
  logic [IW-1:0] scan_idx_q;
  logic [7:0]    seg_q;
  logic [NUM_DIGITS-1:0] sel_q;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 8'h3F;
      4'd1: seg_of = 8'h06;
      4'd2: seg_of = 8'h5B;
      4'd3: seg_of = 8'h4F;
      4'd4: seg_of = 8'h66;
      4'd5: seg_of = 8'h6D;
      4'd6: seg_of = 8'h7D;
      4'd7: seg_of = 8'h07;
      4'd8: seg_of = 8'h7F;
      4'd9: seg_of = 8'h6F;
      default: seg_of = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    step_last  = 1'b0;
    case (state_q)
      S_IDLE, S_SHOW: begin
        if (IN_start) begin
          load_start = 1'b1;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        if (iter_q == 4'd15) begin
          step_last = 1'b1;
          state_d   = S_SHOW;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge IN_clk) begin
    if (IN_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift bcd:bin left.
  logic [19:0] bcd_adj;
  logic [35:0] shifted;
  logic [19:0] bcd_next;
  logic [15:0] bin_next;
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 5; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    shifted  = {bcd_adj, bin_q} << 1;
    bcd_next = shifted[35:16];
    bin_next = shifted[15:0];
  end

  // Digit images for the finished conversion, with leading-zero blanking above digit 0.
  logic [7:0] dig_new [5];
  logic       nz_above;
  always_comb begin
    nz_above = 1'b0;
    for (int i = 0; i < 5; i++) dig_new[i] = 8'h00;
    if (err_q) begin
      dig_new[0] = 8'h50;
      dig_new[1] = 8'h50;
      dig_new[2] = 8'h79;
    end else begin
      for (int i = 4; i >= 1; i--) begin
        nz_above   = nz_above | (bcd_next[4*i +: 4] != 4'd0);
        dig_new[i] = nz_above ? seg_of(bcd_next[4*i +: 4]) : 8'h00;
      end
      dig_new[0] = seg_of(bcd_next[3:0]);
    end
  end

  logic [7:0]            cur_seg;
  logic [NUM_DIGITS-1:0] cur_sel;
  always_comb begin
    cur_seg = 8'h00;
    for (int i = 0; i < 5; i++) begin
      if (scan_idx_q == IW'(i)) cur_seg = dig_q[i];
    end
    cur_sel = NUM_DIGITS'(1) << scan_idx_q;
  end

  always_ff @(posedge IN_clk) begin
    if (IN_reset) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < 5; i++) dig_q[i] <= 8'h00;
      disp_vld_q <= 1'b0;
      done_q     <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= '0;
      sel_q      <= '0;
    end else begin
      done_q <= step_last;
      if (load_start) begin
        bin_q  <= {IN_RESH, IN_RESL};
        bcd_q  <= '0;
        iter_q <= '0;
        err_q  <= IN_err;
      end else if (state_q == S_CONV) begin
        bin_q  <= bin_next;
        bcd_q  <= bcd_next;
        iter_q <= iter_q + 4'd1;
      end
      if (step_last) begin
        for (int i = 0; i < 5; i++) dig_q[i] <= dig_new[i];
        disp_vld_q <= 1'b1;
      end
      if (scan_cnt_q == CW'(SCAN_DIV - 1)) begin
        scan_cnt_q <= '0;
        scan_idx_q <= (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      // The display stays dark until the first conversion since reset has completed.
      seg_q <= disp_vld_q ? cur_seg : 8'h00;
      sel_q <= disp_vld_q ? cur_sel : '0;
    end
  end

  assign OUT_seg   = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign OUT_sel   = (ACTIVE_LOW != 0) ? ~sel_q : sel_q;
  assign OUT_busy  = (state_q == S_CONV);
  assign OUT_done  = done_q;
  assign OUT_state = state_q;

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: stimulus pushes expected frames, and a monitor checks done timing, the scan and the FSM outputs.
module tb_result_display;
  localparam int SD = 4;
  localparam int ND = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       err = 1'b0;
  logic [7:0] resh = 8'h00;
  logic [7:0] resl = 8'h00;
  logic [7:0]    out_seg;
  logic [ND-1:0] out_sel;
  logic          out_busy;
  logic          out_done;
  logic [1:0]    out_state;

  result_display #(.SCAN_DIV(SD), .NUM_DIGITS(ND), .ACTIVE_LOW(0)) dut (
    .IN_clk(clk), .IN_reset(rst), .IN_start(start), .IN_RESH(resh), .IN_RESL(resl),
    .IN_err(err), .OUT_seg(out_seg), .OUT_sel(out_sel), .OUT_busy(out_busy),
    .OUT_done(out_done), .OUT_state(out_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] f;
    int          due;
  } exp_t;
  exp_t q[$];
  int   last_start = -1000;
  bit   stop = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [7:0] seg7(input int d);
    case (d)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Expected 8-position frame from decimal arithmetic: digit i is lit if i==0 or value >= 10^i.
  function automatic logic [63:0] model(input int v, input bit e);
    logic [63:0] f = '0;
    int p = 1;
    if (e) begin
      f[7:0]   = 8'h50;
      f[15:8]  = 8'h50;
      f[23:16] = 8'h79;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (i == 0 || v >= p) f[i*8 +: 8] = seg7((v / p) % 10);
        p = p * 10;
      end
    end
    return f;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input int v, input bit e);
    @(negedge clk);
    resh  = v[15:8];
    resl  = v[7:0];
    err   = e;
    start = 1'b1;
    if (cyc + 1 >= last_start + 17) begin
      last_start = cyc + 1;
      q.push_back('{model(v, e), cyc + 17});
    end
    @(negedge clk);
    start = 1'b0;
    err   = 1'($urandom);
    resh  = 8'($urandom);
    resl  = 8'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(40);
    do_start(12345, 1'b0); idle(40);
    do_start(0, 1'b0);     idle(40);
    do_start(65535, 1'b0); idle(40);
    do_start(7, 1'b0);     idle(4);
    do_start(4321, 1'b0);  idle(40);
    do_start(16'h1234, 1'b1); idle(40);
    do_start(500, 1'b0);   idle(7);
    @(negedge clk);
    rst = 1'b1;
    last_start = -1000;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(40);
    repeat (40) begin
      do_start(int'($urandom_range(0, 65535)), ($urandom_range(0, 7) == 0));
      idle(int'($urandom_range(0, 30)));
    end
    idle(60);
    stop = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, fails=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    bit          armed = 1'b0;
    bit          shown = 1'b0;
    bit          exp_done;
    bit          exp_busy;
    logic [63:0] cur = '0;
    logic [7:0]  exp_sel;
    logic [7:0]  exp_seg;
    int          rst_edge = 0;
    int          idx;
    exp_t        e;
    forever begin
      @(posedge clk);
      #1;
      if (stop) break;
      if (rst) begin
        armed    = 1'b1;
        shown    = 1'b0;
        rst_edge = cyc;
        chk("reset_seg", 64'(out_seg), 64'h0);
        chk("reset_sel", 64'(out_sel), 64'h0);
        chk("reset_busy", 64'(out_busy), 64'h0);
        chk("reset_done", 64'(out_done), 64'h0);
        chk("reset_state", 64'(out_state), 64'h0);
        continue;
      end
      if (!armed) continue;
      idx     = ((cyc - 1 - rst_edge) / SD) % ND;
      exp_sel = shown ? 8'(1 << idx) : 8'h00;
      exp_seg = shown ? cur[idx*8 +: 8] : 8'h00;
      chk("scan_sel", 64'(out_sel), 64'(exp_sel));
      chk("scan_seg", 64'(out_seg), 64'(exp_seg));
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      chk("done", 64'(out_done), 64'(exp_done));
      if (exp_done) begin
        e     = q.pop_front();
        cur   = e.f;
        shown = 1'b1;
      end
      exp_busy = (cyc >= last_start) && (cyc <= last_start + 15);
      chk("busy", 64'(out_busy), 64'(exp_busy));
      chk("state", 64'(out_state), exp_busy ? 64'd1 : (shown ? 64'd2 : 64'd0));
    end
    chk("pending_results", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
